jadepix_ro_sched: RTL and testbench
===================================

// Module: jadepix_ro_sched
// PURPOSE
//  FPGA-side scheduler for the chip peripheral readout: generates Inquiry/Select/ReadEn
//  toward PeripheraReadOut from the per-bank FIFO flags ValidOut[3:0].
//  - Sequences: sync symbol, status word, then data bursts.
//  - Round-robin shares the single 8b10b output link between the four bank FIFOs.
//  - Sits between the slow-control registers and the chip pad drivers, in the CLK_80M domain.
// PARAMETERS
//  NBANK      4    number of bank FIFOs (Select width = $clog2(NBANK))
//  BURST_MAX  160  words per burst when cfg_burst==0
//  SYNC_IDLE  64   consecutive IDLE cycles before an unsolicited sync symbol
//  CNT_W      16   width of the word/burst counters
// PORTS
//  CLK_80M    in   1      readout clock; single clock domain
//  RST        in   1      synchronous reset, active-high
//  sched_en   in   1      level; 1 = run the scheduler
//  cfg_burst  in   8      max words per burst; 0 -> BURST_MAX
//  ValidOut   in   NBANK  per-bank FIFO non-empty flag from the chip
//  Inquiry    out  2      00 sync symbol, 01 data word, 10 status word, 11 idle
//  Select     out  2      FIFO index, meaningful only while Inquiry==01
//  ReadEn     out  1      chip readout enable
//  busy       out  1      1 in any state except IDLE
//  cur_bank   out  2      bank of the current or last burst
//  burst_cnt  out  CNT_W  completed bursts; wraps
// BEHAVIOUR
//  Reset: Inquiry=11, Select=0, ReadEn=0, busy=0, cur_bank=0, burst_cnt=0,
//    RR pointer=0 (bank0 highest priority), idle timer=0, state=IDLE.
//  Outputs are registered and change together with the state; no combinational input->output path.
//  States:
//  - IDLE: Inquiry=11.
//    - sched_en=1 && !ReadEn -> SYNC.
//    - sched_en=1 && any ValidOut -> STAT.
//    - Idle timer counts cycles spent in IDLE; at SYNC_IDLE-1 -> SYNC (timer cleared).
//  - SYNC: Inquiry=00 for 1 cycle; sets ReadEn=1; -> STAT.
//  - STAT: Inquiry=10 for 1 cycle; -> ARB.
//  - ARB: 1 cycle, Inquiry=11. Sample ValidOut; grant the first set bit at or after the RR pointer.
//    - Grant -> READ; Select=cur_bank=grant; RR pointer=grant+1 mod NBANK; word count=0.
//    - No grant -> IDLE.
//  - READ: Inquiry=01. Each word holds Inquiry=01 and a stable Select for exactly 2 cycles.
//    - On the 2nd cycle of each word: word count++; ValidOut[cur_bank] is sampled.
//    - Burst ends after the word that reaches the limit (cfg_burst, or BURST_MAX if 0), or
//      after a word where the sampled flag was 0. Then burst_cnt++ (wraps) -> STAT.
//  sched_en=0:
//  - Never aborts a word. Within READ, the current 2-cycle word completes, then -> IDLE.
//  - SYNC/STAT/ARB also exit to IDLE.
//  - In IDLE with sched_en=0: ReadEn=0, idle timer held at 0.
//  Simultaneous events: the SYNC_IDLE timeout and a ValidOut request in the same IDLE cycle -> SYNC
//    first, then STAT.
//  RST asserted in any state, mid-word included: next cycle shows the reset values exactly.
//  cfg_burst is sampled in ARB; changes during READ take effect on the next burst.
// CONFIGURATION
//  JADEPIX_SCHED_STATS_EN defined:
//  - Adds output words_out [NBANK*CNT_W], per-bank count of completed data words.
//  - Counters saturate at all-ones and clear on RST.
//  Not defined: port and counters absent; all other behaviour identical.
// STRUCTURE
//  Package jadepix_ro_pkg:
//  - typedef enum logic[1:0] inq_t {INQ_SYNC=2'b00, INQ_DATA=2'b01, INQ_STAT=2'b10, INQ_IDLE=2'b11}.
//  - typedef enum sched_state_t {IDLE, SYNC, STAT, ARB, READ}.
//  - localparam NBANK_DEF=4.
//  Sub-module jadepix_ro_rr_arb: combinational NBANK round-robin grant from req and pointer;
//    outputs gnt_valid and gnt_idx. The pointer register lives in the parent.
// TESTING
//  1 RST high 3 cycles, sched_en=0 -> Inquiry=11, ReadEn=0, busy=0 held throughout.
//  2 sched_en=1, ValidOut=0000 -> 00 (ReadEn=1), 10, 11 on ARB, then 11 x64, then 00 again.
//  3 ValidOut=0001, cfg_burst=4 -> after 00,10 and ARB: Inquiry=01/Select=0 for 8 cycles, then 10; burst_cnt=1.
//  4 ValidOut=1111 constant, cfg_burst=1 -> Select sequence 0,1,2,3,0 across bursts, each separated by 10 and ARB.
//  5 ValidOut[2] only, cfg_burst=4; ValidOut[2] cleared during word 2 -> exactly 4 data cycles, then 10.
//  6 sched_en dropped on 1st cycle of a word -> 2nd cycle still 01, then 11 with ReadEn=0.
//    Separately, RST during READ -> reset values on the next cycle.

Source files
------------

// File: rtl/jadepix_ro_pkg.sv
// Shared types for the JadePix peripheral readout scheduler: Inquiry codes,
// scheduler states and the state-to-Inquiry mapping.
package jadepix_ro_pkg;

    typedef enum logic [1:0] {
        INQ_SYNC = 2'b00,
        INQ_DATA = 2'b01,
        INQ_STAT = 2'b10,
        INQ_IDLE = 2'b11
    } inq_t;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        STAT,
        ARB,
        READ
    } sched_state_t;

    localparam int NBANK_DEF = 4;

    // Inquiry code shown on the link while the scheduler sits in a state.
    function automatic inq_t inq_for_state(input sched_state_t s);
        case (s)
            SYNC:    return INQ_SYNC;
            STAT:    return INQ_STAT;
            READ:    return INQ_DATA;
            default: return INQ_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/jadepix_ro_rr_arb.sv
// Combinational round-robin grant: first requesting bank at or after ptr.
// The pointer register is owned by the parent.
module jadepix_ro_rr_arb #(
    parameter int NBANK = 4
) (
    input  logic [NBANK-1:0]         req,
    input  logic [$clog2(NBANK)-1:0] ptr,
    output logic                     gnt_valid,
    output logic [$clog2(NBANK)-1:0] gnt_idx
);
    localparam int SEL_W = $clog2(NBANK);

    logic [SEL_W-1:0] idx;

    // Walk from the farthest offset down so the nearest requester wins last.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        for (int i = NBANK - 1; i >= 0; i--) begin
            idx = SEL_W'((int'(ptr) + i) % NBANK);
            if (req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/jadepix_ro_sched.sv
// Readout scheduler: sync, status, then round-robin data bursts over the bank FIFOs.
// Optional per-bank word statistics are enabled with JADEPIX_SCHED_STATS_EN.
module jadepix_ro_sched
    import jadepix_ro_pkg::*;
#(
    parameter int NBANK     = NBANK_DEF,
    parameter int BURST_MAX = 160,
    parameter int SYNC_IDLE = 64,
    parameter int CNT_W     = 16
) (
    input  logic                     CLK_80M,
    input  logic                     RST,
    input  logic                     sched_en,
    input  logic [7:0]               cfg_burst,
    input  logic [NBANK-1:0]         ValidOut,
    output logic [1:0]               Inquiry,
    output logic [$clog2(NBANK)-1:0] Select,
    output logic                     ReadEn,
    output logic                     busy,
    output logic [$clog2(NBANK)-1:0] cur_bank,
    output logic [CNT_W-1:0]         burst_cnt,
    output sched_state_t             dbgState
`ifdef JADEPIX_SCHED_STATS_EN
    ,
    output logic [NBANK*CNT_W-1:0]   words_out
`endif
);
    localparam int SEL_W = $clog2(NBANK);

    sched_state_t     state, nextState;
    logic [SEL_W-1:0] rrPtr;
    logic [CNT_W-1:0] wordCnt, burstLim, idleTmr;
    logic             phase;
    logic             gntValid;
    logic [SEL_W-1:0] gntIdx;
    logic             wordDone, burstEnd;

    jadepix_ro_rr_arb #(.NBANK(NBANK)) u_arb (
        .req       (ValidOut),
        .ptr       (rrPtr),
        .gnt_valid (gntValid),
        .gnt_idx   (gntIdx)
    );

    // A word spans two READ cycles; phase marks its second cycle.
    assign wordDone = (state == READ) && phase;
    assign burstEnd = wordDone &&
                      ((wordCnt + CNT_W'(1) >= burstLim) || !ValidOut[cur_bank]);
    assign dbgState = state;

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (sched_en) begin
                    if (!ReadEn || idleTmr == CNT_W'(SYNC_IDLE - 1))
                        nextState = SYNC;
                    else if (|ValidOut)
                        nextState = STAT;
                end
            end
            SYNC:    nextState = sched_en ? STAT : IDLE;
            STAT:    nextState = sched_en ? ARB : IDLE;
            ARB:     nextState = (sched_en && gntValid) ? READ : IDLE;
            READ: begin
                if (phase) begin
                    if (!sched_en)
                        nextState = IDLE;
                    else if (burstEnd)
                        nextState = STAT;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge CLK_80M) begin
        if (RST) begin
            state     <= IDLE;
            Inquiry   <= INQ_IDLE;
            Select    <= '0;
            ReadEn    <= 1'b0;
            busy      <= 1'b0;
            cur_bank  <= '0;
            burst_cnt <= '0;
            rrPtr     <= '0;
            idleTmr   <= '0;
            wordCnt   <= '0;
            burstLim  <= '0;
            phase     <= 1'b0;
        end else begin
            state   <= nextState;
            Inquiry <= inq_for_state(nextState);
            busy    <= (nextState != IDLE);
            idleTmr <= (state == IDLE && nextState == IDLE && sched_en) ?
                       idleTmr + CNT_W'(1) : '0;

            // ReadEn rises with the sync symbol and drops when disabled into IDLE.
            if (nextState == SYNC)
                ReadEn <= 1'b1;
            else if (nextState == IDLE && !sched_en)
                ReadEn <= 1'b0;

            if (state == ARB && nextState == READ) begin
                Select   <= gntIdx;
                cur_bank <= gntIdx;
                rrPtr    <= (gntIdx == SEL_W'(NBANK - 1)) ? '0 : gntIdx + 1'b1;
                wordCnt  <= '0;
                phase    <= 1'b0;
                burstLim <= (cfg_burst == 8'd0) ? CNT_W'(BURST_MAX) : CNT_W'(cfg_burst);
            end else if (state == READ) begin
                phase <= ~phase;
                if (phase)
                    wordCnt <= wordCnt + CNT_W'(1);
                if (burstEnd)
                    burst_cnt <= burst_cnt + CNT_W'(1);
            end
        end
    end

`ifdef JADEPIX_SCHED_STATS_EN
    logic [CNT_W-1:0] wordsCnt [NBANK];

    always_ff @(posedge CLK_80M) begin
        if (RST) begin
            for (int i = 0; i < NBANK; i++)
                wordsCnt[i] <= '0;
        end else if (wordDone && wordsCnt[cur_bank] != '1) begin
            wordsCnt[cur_bank] <= wordsCnt[cur_bank] + CNT_W'(1);
        end
    end

    always_comb begin
        words_out = '0;
        for (int i = 0; i < NBANK; i++)
            words_out[i*CNT_W +: CNT_W] = wordsCnt[i];
    end
`endif

endmodule

// File: tb/tb_jadepix_ro_sched.sv
// Self-checking bench for jadepix_ro_sched: directed scenarios plus randomized
// bursts checked against a token-level trace model of the link.
module tb_jadepix_ro_sched;

    logic        CLK_80M = 1'b0;
    logic        RST = 1'b1;
    logic        sched_en = 1'b0;
    logic [7:0]  cfg_burst = 8'd0;
    logic [3:0]  ValidOut = 4'd0;
    logic [1:0]  Inquiry;
    logic [1:0]  Select;
    logic        ReadEn;
    logic        busy;
    logic [1:0]  cur_bank;
    logic [15:0] burst_cnt;
    logic [2:0]  dbg_state;

    int compared = 0;
    int mismatched = 0;

    // Entry: {readEn, busy, checkSel, inquiry[1:0], sel[1:0], burstCount[7:0]}
    logic [14:0] exp_q[$];

    always #5 CLK_80M = ~CLK_80M;

    jadepix_ro_sched dut (
        .CLK_80M   (CLK_80M),
        .RST       (RST),
        .sched_en  (sched_en),
        .cfg_burst (cfg_burst),
        .ValidOut  (ValidOut),
        .Inquiry   (Inquiry),
        .Select    (Select),
        .ReadEn    (ReadEn),
        .busy      (busy),
        .cur_bank  (cur_bank),
        .burst_cnt (burst_cnt),
        .dbgState  (dbg_state)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", compared);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK_80M);
        #1;
    endtask

    function automatic logic [14:0] mk(input logic re, input logic bz, input logic cs,
                                       input logic [1:0] inq, input int sel, input int bcnt);
        logic [31:0] s;
        logic [31:0] b;
        s = sel;
        b = bcnt;
        return {re, bz, cs, inq, s[1:0], b[7:0]};
    endfunction

    task automatic apply_reset();
        RST = 1'b1;
        sched_en = 1'b0;
        ValidOut = 4'd0;
        cfg_burst = 8'd0;
        repeat (3) tick();
    endtask

    task automatic release_run(input logic [3:0] vo, input logic [7:0] cfg);
        ValidOut = vo;
        cfg_burst = cfg;
        sched_en = 1'b1;
        RST = 1'b0;
    endtask

    // Link-level model: every burst is STAT, ARB, then 2 cycles per word from the
    // round-robin winner; flags stay set so each burst runs to its word limit.
    task automatic model_bursts(input logic [3:0] mask, input logic [7:0] cfg, input int nb,
                                inout int ptr, inout int bcnt);
        int lim;
        int g;
        lim = (cfg == 8'd0) ? 160 : int'(cfg);
        for (int b = 0; b < nb; b++) begin
            exp_q.push_back(mk(1, 1, 0, 2'b10, 0, bcnt));
            exp_q.push_back(mk(1, 1, 0, 2'b11, 0, bcnt));
            g = -1;
            for (int k = 0; k < 4; k++)
                if (g < 0 && mask[(ptr + k) % 4]) g = (ptr + k) % 4;
            for (int w = 0; w < 2 * lim; w++)
                exp_q.push_back(mk(1, 1, 1, 2'b01, g, bcnt));
            ptr = (g + 1) % 4;
            bcnt++;
        end
    endtask

    // Drains exp_q one cycle per entry; after entry actIdx applies act
    // (1: clear ValidOut, 2: drop sched_en).
    task automatic run_trace(input string name, input int actIdx, input int act);
        logic [14:0] e;
        int idx;
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tick();
            compared++;
            if (Inquiry !== e[11:10] || busy !== e[13] || ReadEn !== e[14] ||
                burst_cnt !== {8'd0, e[7:0]} ||
                (e[12] && (Select !== e[9:8] || cur_bank !== e[9:8]))) begin
                mismatched++;
                $display("FAIL %s[%0d]: got inq=%b sel=%0d bank=%0d re=%b busy=%b bcnt=%0d; want inq=%b sel=%0d re=%b busy=%b bcnt=%0d",
                         name, idx, Inquiry, Select, cur_bank, ReadEn, busy, burst_cnt,
                         e[11:10], e[9:8], e[14], e[13], e[7:0]);
            end
            if (idx == actIdx) begin
                if (act == 1) ValidOut = 4'd0;
                else if (act == 2) sched_en = 1'b0;
            end
            idx++;
        end
    endtask

    task automatic check_reset_values(input string name);
        compared++;
        if (Inquiry !== 2'b11 || ReadEn !== 1'b0 || busy !== 1'b0 || Select !== 2'd0 ||
            cur_bank !== 2'd0 || burst_cnt !== 16'd0) begin
            mismatched++;
            $display("FAIL %s: got inq=%b re=%b busy=%b sel=%0d bank=%0d bcnt=%0d; want inq=11 re=0 busy=0 sel=0 bank=0 bcnt=0",
                     name, Inquiry, ReadEn, busy, Select, cur_bank, burst_cnt);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        sched_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_reset_values("reset_hold");
        end
        // Disabled scheduler must never start, even with requests and past the idle timeout.
        RST = 1'b0;
        ValidOut = 4'hF;
        for (int i = 0; i < 70; i++) begin
            tick();
            check_reset_values("disabled_idle");
        end
    endtask

    task automatic test_idle_sync();
        apply_reset();
        release_run(4'b0000, 8'd4);
        exp_q.push_back(mk(1, 1, 0, 2'b00, 0, 0));
        exp_q.push_back(mk(1, 1, 0, 2'b10, 0, 0));
        exp_q.push_back(mk(1, 1, 0, 2'b11, 0, 0));
        for (int i = 0; i < 64; i++)
            exp_q.push_back(mk(1, 0, 0, 2'b11, 0, 0));
        exp_q.push_back(mk(1, 1, 0, 2'b00, 0, 0));
        exp_q.push_back(mk(1, 1, 0, 2'b10, 0, 0));
        exp_q.push_back(mk(1, 1, 0, 2'b11, 0, 0));
        exp_q.push_back(mk(1, 0, 0, 2'b11, 0, 0));
        run_trace("idle_sync", -1, 0);
    endtask

    task automatic test_single_bank();
        int ptr;
        int bcnt;
        ptr = 0;
        bcnt = 0;
        apply_reset();
        release_run(4'b0001, 8'd4);
        exp_q.push_back(mk(1, 1, 0, 2'b00, 0, 0));
        model_bursts(4'b0001, 8'd4, 1, ptr, bcnt);
        exp_q.push_back(mk(1, 1, 0, 2'b10, 0, bcnt));
        run_trace("single_bank", -1, 0);
    endtask

    task automatic test_round_robin();
        int ptr;
        int bcnt;
        ptr = 0;
        bcnt = 0;
        apply_reset();
        release_run(4'b1111, 8'd1);
        exp_q.push_back(mk(1, 1, 0, 2'b00, 0, 0));
        model_bursts(4'b1111, 8'd1, 5, ptr, bcnt);
        exp_q.push_back(mk(1, 1, 0, 2'b10, 0, bcnt));
        run_trace("round_robin", -1, 0);
    endtask

    task automatic test_flag_drop();
        apply_reset();
        release_run(4'b0100, 8'd4);
        exp_q.push_back(mk(1, 1, 0, 2'b00, 0, 0));
        exp_q.push_back(mk(1, 1, 0, 2'b10, 0, 0));
        exp_q.push_back(mk(1, 1, 0, 2'b11, 0, 0));
        for (int i = 0; i < 4; i++)
            exp_q.push_back(mk(1, 1, 1, 2'b01, 2, 0));
        exp_q.push_back(mk(1, 1, 0, 2'b10, 0, 1));
        exp_q.push_back(mk(1, 1, 0, 2'b11, 0, 1));
        exp_q.push_back(mk(1, 0, 0, 2'b11, 0, 1));
        exp_q.push_back(mk(1, 0, 0, 2'b11, 0, 1));
        run_trace("flag_drop", 5, 1);
    endtask

    task automatic test_sched_drop();
        apply_reset();
        release_run(4'b0001, 8'd4);
        exp_q.push_back(mk(1, 1, 0, 2'b00, 0, 0));
        exp_q.push_back(mk(1, 1, 0, 2'b10, 0, 0));
        exp_q.push_back(mk(1, 1, 0, 2'b11, 0, 0));
        exp_q.push_back(mk(1, 1, 1, 2'b01, 0, 0));
        exp_q.push_back(mk(1, 1, 1, 2'b01, 0, 0));
        for (int i = 0; i < 3; i++)
            exp_q.push_back(mk(0, 0, 0, 2'b11, 0, 0));
        run_trace("sched_drop", 3, 2);
    endtask

    task automatic test_rst_read();
        apply_reset();
        release_run(4'b0010, 8'd1);
        exp_q.push_back(mk(1, 1, 0, 2'b00, 0, 0));
        exp_q.push_back(mk(1, 1, 0, 2'b10, 0, 0));
        exp_q.push_back(mk(1, 1, 0, 2'b11, 0, 0));
        exp_q.push_back(mk(1, 1, 1, 2'b01, 1, 0));
        exp_q.push_back(mk(1, 1, 1, 2'b01, 1, 0));
        exp_q.push_back(mk(1, 1, 0, 2'b10, 0, 1));
        exp_q.push_back(mk(1, 1, 0, 2'b11, 0, 1));
        exp_q.push_back(mk(1, 1, 1, 2'b01, 1, 1));
        run_trace("rst_read_pre", -1, 0);
        RST = 1'b1;
        tick();
        check_reset_values("rst_mid_word");
        RST = 1'b0;
    endtask

    task automatic test_random();
        logic [3:0] mask;
        logic [7:0] cfg;
        int nb;
        int ptr;
        int bcnt;
        for (int it = 0; it < 8; it++) begin
            mask = 4'($urandom_range(1, 15));
            cfg = 8'($urandom_range(0, 5));
            nb = int'($urandom_range(2, 6));
            ptr = 0;
            bcnt = 0;
            apply_reset();
            release_run(mask, cfg);
            exp_q.push_back(mk(1, 1, 0, 2'b00, 0, 0));
            model_bursts(mask, cfg, nb, ptr, bcnt);
            exp_q.push_back(mk(1, 1, 0, 2'b10, 0, bcnt));
            run_trace($sformatf("random%0d_m%b_c%0d", it, mask, cfg), -1, 0);
        end
    endtask

    initial begin
        test_reset();
        test_idle_sync();
        test_single_bank();
        test_round_robin();
        test_flag_drop();
        test_sched_drop();
        test_rst_read();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
